// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, next-PC controller states and target selects.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default byte increment for sequential instruction fetch.
  localparam int unsigned PC_STRIDE_DEF = 4;

  // Next-PC controller states.
  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2,
    HALTED  = 2'd3
  } npc_state_t;

  // Which target the calculator produces.
  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } npc_sel_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target arithmetic; all sums wrap modulo 2^32.
module pc_target_calc
  import cpu_types_pkg::*;
#(
  parameter int unsigned PC_STRIDE = PC_STRIDE_DEF
) (
  input  word_t       count,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  word_t       jr_target,
  input  npc_sel_t    select,
  output word_t       target
);

  word_t w_pc_plus4;
  word_t w_seq;
  word_t w_br_off;

  assign w_pc_plus4 = count + 32'd4;
  assign w_seq      = count + 32'(PC_STRIDE);
  // Word offset, sign-extended and scaled to bytes.
  assign w_br_off   = {{14{imm16[15]}}, imm16, 2'b00};

  // Select the requested target; jr_target passes through untouched.
  always_comb begin
    target = w_seq;
    case (select)
      SEL_SEQ: target = w_seq;
      SEL_BR:  target = w_pc_plus4 + w_br_off;
      SEL_J:   target = {w_pc_plus4[31:28], jaddr, 2'b00};
      SEL_JR:  target = jr_target;
      default: target = w_seq;
    endcase
  end

endmodule

// File: rtl/next_pc_ctrl.sv
// Next-PC controller: decides when the program counter loads and with what.
// countEn/next_count feed the program_counter_if of the PC register.
// Handshake: a fetch completes when iREN=1 and ihit=1 in the same cycle; only
// then is countEn raised, so the PC advances exactly once per returned word.
// Redirect pulses seen without ihit are parked in r_target (HOLD) until ihit.
module next_pc_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 1,
  parameter int unsigned PC_STRIDE      = PC_STRIDE_DEF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  word_t       count,
  input  logic        ihit,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic        jump,
  input  logic [25:0] jaddr,
  input  logic        jr,
  input  word_t       jr_target,
  input  logic        halt,
  output logic        countEn,
  output word_t       next_count,
  output logic        iREN,
  output logic        halted,
  output logic        redirect_pending,
  output npc_state_t  o_dbg_state
);

  npc_state_t r_state, w_state_nxt;
  word_t      r_target, w_target_nxt;
  word_t      r_start_cnt, w_start_cnt_nxt;

  npc_sel_t   w_sel;
  word_t      w_target;
  logic       w_redirect;

  assign w_redirect = jr | jump | branch_taken;

  // Redirect priority jr > jump > branch; outside RUN/HOLD only sequential.
  always_comb begin
    w_sel = SEL_SEQ;
    if (r_state == RUN || r_state == HOLD) begin
      if (jr)                w_sel = SEL_JR;
      else if (jump)         w_sel = SEL_J;
      else if (branch_taken) w_sel = SEL_BR;
    end
  end

  pc_target_calc #(
    .PC_STRIDE (PC_STRIDE)
  ) u_calc (
    .count     (count),
    .imm16     (imm16),
    .jaddr     (jaddr),
    .jr_target (jr_target),
    .select    (w_sel),
    .target    (w_target)
  );

  // State, latched redirect target and startup counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= STARTUP;
      r_target    <= '0;
      r_start_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_target    <= w_target_nxt;
      r_start_cnt <= w_start_cnt_nxt;
    end
  end

  // Next state and fetch outputs; halt beats any redirect or ihit.
  always_comb begin
    w_state_nxt     = r_state;
    w_target_nxt    = r_target;
    w_start_cnt_nxt = r_start_cnt;
    countEn         = 1'b0;
    next_count      = w_target;
    case (r_state)
      STARTUP: begin
        if ((r_start_cnt + 32'd1) >= 32'(STARTUP_CYCLES)) w_state_nxt = RUN;
        else w_start_cnt_nxt = r_start_cnt + 32'd1;
      end
      RUN: begin
        if (halt) begin
          w_state_nxt  = HALTED;
          w_target_nxt = '0;
        end else if (ihit) begin
          countEn = 1'b1;
        end else if (w_redirect) begin
          w_target_nxt = w_target;
          w_state_nxt  = HOLD;
        end
      end
      HOLD: begin
        next_count = r_target;
        if (halt) begin
          w_state_nxt  = HALTED;
          w_target_nxt = '0;
        end else if (w_redirect) begin
          // Newest redirect replaces the parked one.
          if (ihit) begin
            countEn      = 1'b1;
            next_count   = w_target;
            w_state_nxt  = RUN;
            w_target_nxt = '0;
          end else begin
            w_target_nxt = w_target;
          end
        end else if (ihit) begin
          countEn      = 1'b1;
          w_state_nxt  = RUN;
          w_target_nxt = '0;
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt  = STARTUP;
        w_target_nxt = '0;
      end
    endcase
  end

  assign iREN             = (r_state == RUN) || (r_state == HOLD);
  assign halted           = (r_state == HALTED);
  assign redirect_pending = (r_state == HOLD);
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Directed bench for next_pc_ctrl with hand-computed expectations.
module tb_next_pc_ctrl;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  word_t       count;
  logic        ihit;
  logic        branch_taken;
  logic [15:0] imm16;
  logic        jump;
  logic [25:0] jaddr;
  logic        jr;
  word_t       jr_target;
  logic        halt;
  logic        countEn;
  word_t       next_count;
  logic        iREN;
  logic        halted;
  logic        redirect_pending;
  npc_state_t  o_dbg_state;

  int n_checks;
  int n_fail;

  next_pc_ctrl #(
    .STARTUP_CYCLES (1),
    .PC_STRIDE      (4)
  ) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .count            (count),
    .ihit             (ihit),
    .branch_taken     (branch_taken),
    .imm16            (imm16),
    .jump             (jump),
    .jaddr            (jaddr),
    .jr               (jr),
    .jr_target        (jr_target),
    .halt             (halt),
    .countEn          (countEn),
    .next_count       (next_count),
    .iREN             (iREN),
    .halted           (halted),
    .redirect_pending (redirect_pending),
    .o_dbg_state      (o_dbg_state)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and drop all one-cycle pulses.
  task automatic tick();
    @(negedge CLK);
    jr           = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    halt         = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    nRST         = 1'b0;
    count        = 32'h0;
    ihit         = 1'b1;
    branch_taken = 1'b0;
    imm16        = 16'h0;
    jump         = 1'b0;
    jaddr        = 26'h0;
    jr           = 1'b0;
    jr_target    = 32'h0;
    halt         = 1'b0;

    // Reset state
    tick(); tick(); #1;
    check_eq("rst_countEn", 32'(countEn), 32'd0);
    check_eq("rst_iREN", 32'(iREN), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_pending", 32'(redirect_pending), 32'd0);
    check_eq("rst_state", 32'(o_dbg_state), 32'(STARTUP));

    // Startup: one cycle with countEn=0, then sequential fetch
    tick(); nRST = 1'b1; #1;
    check_eq("startup_countEn", 32'(countEn), 32'd0);
    check_eq("startup_next", next_count, 32'h4);
    tick(); #1;
    check_eq("run_countEn", 32'(countEn), 32'd1);
    check_eq("run_next_seq", next_count, 32'h4);
    check_eq("run_iREN", 32'(iREN), 32'd1);

    // Branch with negative offset: 0x104 - 4
    tick(); count = 32'h100; branch_taken = 1'b1; imm16 = 16'hFFFF; #1;
    check_eq("br_neg", next_count, 32'h100);
    check_eq("br_neg_en", 32'(countEn), 32'd1);
    // Jump beats branch: {0, 0x40, 00}
    tick(); branch_taken = 1'b1; jump = 1'b1; jaddr = 26'h40; imm16 = 16'h0010; #1;
    check_eq("jump_over_br", next_count, 32'h100);
    // Branch with positive offset: 0x104 + 0x40
    tick(); branch_taken = 1'b1; imm16 = 16'h0010; #1;
    check_eq("br_pos", next_count, 32'h144);
    // jr beats jump and branch
    tick(); jr = 1'b1; jump = 1'b1; branch_taken = 1'b1; jr_target = 32'h0000_1236; #1;
    check_eq("jr_over_all", next_count, 32'h0000_1236);
    // Jump region taken from count+4 carrying into bit 28
    tick(); count = 32'h1FFF_FFFC; jump = 1'b1; jaddr = 26'h1; #1;
    check_eq("jump_region", next_count, 32'h2000_0004);
    tick(); count = 32'hF000_0000; jump = 1'b1; jaddr = 26'h3FF_FFFF; #1;
    check_eq("jump_max", next_count, 32'hFFFF_FFFC);
    // Sequential wrap
    tick(); count = 32'hFFFF_FFFC; #1;
    check_eq("seq_wrap", next_count, 32'h0);
    check_eq("seq_wrap_en", 32'(countEn), 32'd1);

    // jr while ihit=0 parks in HOLD
    tick(); count = 32'h200; ihit = 1'b0; jr = 1'b1; jr_target = 32'h8000; #1;
    check_eq("jr_miss_en", 32'(countEn), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check_eq("hold_pending", 32'(redirect_pending), 32'd1);
      check_eq("hold_en", 32'(countEn), 32'd0);
      check_eq("hold_next", next_count, 32'h8000);
    end
    tick(); ihit = 1'b1; #1;
    check_eq("hold_hit_en", 32'(countEn), 32'd1);
    check_eq("hold_hit_next", next_count, 32'h8000);
    tick(); #1;
    check_eq("after_hold_pending", 32'(redirect_pending), 32'd0);
    check_eq("after_hold_next", next_count, 32'h204);

    // Newest redirect wins in HOLD
    tick(); ihit = 1'b0; jump = 1'b1; jaddr = 26'h10; #1;
    tick(); branch_taken = 1'b1; imm16 = 16'h0002; #1;
    check_eq("hold_old_next", next_count, 32'h40);
    tick(); #1;
    check_eq("hold_new_next", next_count, 32'h20C);
    tick(); ihit = 1'b1; jr = 1'b1; jr_target = 32'h3000; #1;
    check_eq("hold_direct_next", next_count, 32'h3000);
    check_eq("hold_direct_en", 32'(countEn), 32'd1);
    tick(); #1;
    check_eq("hold_direct_run", 32'(o_dbg_state), 32'(RUN));

    // Asynchronous reset mid-HOLD
    tick(); ihit = 1'b0; jr = 1'b1; jr_target = 32'h8000; #1;
    tick(); ihit = 1'b1; #1;
    check_eq("pre_rst_pending", 32'(redirect_pending), 32'd1);
    check_eq("pre_rst_en", 32'(countEn), 32'd1);
    #2 nRST = 1'b0; #1;
    check_eq("async_rst_pending", 32'(redirect_pending), 32'd0);
    check_eq("async_rst_en", 32'(countEn), 32'd0);
    tick(); nRST = 1'b1; #1;
    check_eq("rerun_startup", 32'(o_dbg_state), 32'(STARTUP));
    tick(); #1;
    check_eq("no_redirect_survives", next_count, 32'h204);
    check_eq("rerun_en", 32'(countEn), 32'd1);

    // Halt overrides jump and ihit
    tick(); halt = 1'b1; jump = 1'b1; jaddr = 26'h40; #1;
    check_eq("halt_en", 32'(countEn), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      check_eq("halted", 32'(halted), 32'd1);
      check_eq("halted_iREN", 32'(iREN), 32'd0);
      check_eq("halted_en", 32'(countEn), 32'd0);
    end
    check_eq("halted_next", next_count, 32'h204);
    tick(); nRST = 1'b0; #1;
    check_eq("halt_rst_state", 32'(o_dbg_state), 32'(STARTUP));
    check_eq("halt_rst_halted", 32'(halted), 32'd0);
    tick(); nRST = 1'b1; #1;
    tick(); #1;
    check_eq("halt_rst_run", 32'(o_dbg_state), 32'(RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
